x_stream_serializer: RTL and testbench

Parallel-to-serial stimulus stage that sits directly upstream of the 2-bit Moore machine and drives its serial input `x`. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out on `x`, one bit per clock. It then optionally holds `x` low for a programmable idle gap. Bit patterns such as 0,1,0,1 held one clock each can therefore be fed to the FSM from a word source, not from hand-timed stimulus.

---
 rtl/x_stream_serializer_pkg.sv | 17 +
 rtl/x_stream_serializer.sv | 125 ++++++++++++
 tb/tb_x_stream_serializer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/x_stream_serializer_pkg.sv
// Shared definitions for the serial stimulus stage: state encoding and counter sizing.
package x_stream_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // The counter holds bit and gap counts up to and including their terminal value.
    function automatic int cnt_width(input int width, input int gap);
        int m;
        m = (width > gap) ? width : gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/x_stream_serializer.sv
// Parallel-to-serial stage: accepts a word over valid/ready and presents it on x one bit
// per clock, optionally followed by an idle gap with x held low.
module x_stream_serializer
    import x_stream_serializer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0,
    parameter int MSB_FIRST  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             busy,
    output logic             done
);

    localparam int              CNT_W    = cnt_width(WIDTH, GAP_CYCLES);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit              NO_GAP   = (GAP_CYCLES == 0);
    localparam bit              MSB_F    = (MSB_FIRST != 0);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               x_q, x_d;
    logic               done_q, done_d;

    logic               last_bit;
    logic               accept;
    logic               first_bit;
    logic               next_bit;
    logic [WIDTH-1:0]   load_rest;
    logic [WIDTH-1:0]   shift_rest;

    // x_q already shows the first bit, so the shift register keeps only what remains.
    always_comb begin
        first_bit  = MSB_F ? din[WIDTH-1]     : din[0];
        load_rest  = MSB_F ? (din << 1)       : (din >> 1);
        next_bit   = MSB_F ? shreg_q[WIDTH-1] : shreg_q[0];
        shift_rest = MSB_F ? (shreg_q << 1)   : (shreg_q >> 1);
    end

    always_comb begin
        last_bit  = (state_q == ST_SHIFT) && (cnt_q == LAST_BIT);
        case (state_q)
            ST_SHIFT: din_ready = last_bit && NO_GAP;
            ST_GAP:   din_ready = 1'b0;
            default:  din_ready = 1'b1;
        endcase
        accept = din_valid && din_ready;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        x_d     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_SHIFT: begin
                if (!last_bit) begin
                    x_d     = next_bit;
                    shreg_d = shift_rest;
                    cnt_d   = cnt_q + CNT_ONE;
                    done_d  = ((cnt_q + CNT_ONE) == LAST_BIT);
                end else if (!NO_GAP) begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_ONE;
                end else if (accept) begin
                    x_d     = first_bit;
                    shreg_d = load_rest;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                // Also recovers the unused encoding 2'd3 as IDLE.
                state_d = ST_IDLE;
                cnt_d   = '0;
                if (accept) begin
                    state_d = ST_SHIFT;
                    x_d     = first_bit;
                    shreg_d = load_rest;
                    cnt_d   = CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            x_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            x_q     <= x_d;
            done_q  <= done_d;
        end
    end

    assign x    = x_q;
    assign done = done_q;
    assign busy = (state_q == ST_SHIFT) || (state_q == ST_GAP);

endmodule

// File: tb/tb_x_stream_serializer.sv
// Directed bench for x_stream_serializer across three parameter sets.
module tb_x_stream_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: WIDTH=4, GAP=0, MSB first
    logic       rst_a, valid_a, ready_a, x_a, busy_a, done_a;
    logic [3:0] din_a;
    // Instance B: WIDTH=4, GAP=2, LSB first
    logic       rst_b, valid_b, ready_b, x_b, busy_b, done_b;
    logic [3:0] din_b;
    // Instance C: WIDTH=8, GAP=0, MSB first
    logic       rst_c, valid_c, ready_c, x_c, busy_c, done_c;
    logic [7:0] din_c;

    x_stream_serializer #(.WIDTH(4), .GAP_CYCLES(0), .MSB_FIRST(1)) u_a (
        .clk(clk), .rst(rst_a), .din(din_a), .din_valid(valid_a),
        .din_ready(ready_a), .x(x_a), .busy(busy_a), .done(done_a));

    x_stream_serializer #(.WIDTH(4), .GAP_CYCLES(2), .MSB_FIRST(0)) u_b (
        .clk(clk), .rst(rst_b), .din(din_b), .din_valid(valid_b),
        .din_ready(ready_b), .x(x_b), .busy(busy_b), .done(done_b));

    x_stream_serializer #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(1)) u_c (
        .clk(clk), .rst(rst_c), .din(din_c), .din_valid(valid_c),
        .din_ready(ready_c), .x(x_c), .busy(busy_c), .done(done_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ex_x, ex_d, ex_b, ex_r;
        logic [7:0] exc;

        rst_a = 1'b1; valid_a = 1'b1; din_a = 4'b0101;
        rst_b = 1'b1; valid_b = 1'b0; din_b = '0;
        rst_c = 1'b1; valid_c = 1'b0; din_c = '0;

        // Reset held two cycles with valid asserted: nothing may be accepted
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_x", x_a, 0);
            chk("rst_busy", busy_a, 0);
            chk("rst_done", done_a, 0);
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; valid_a = 1'b0;
        chk("rst_ready_a", ready_a, 1);
        chk("rst_ready_b", ready_b, 1);
        tick();
        chk("post_rst_busy", busy_a, 0);
        chk("post_rst_x", x_a, 0);

        // Single word 0101, MSB first
        din_a = 4'b0101; valid_a = 1'b1;
        ex_x = 8'b0101_0000; ex_d = 8'b0001_0000; ex_b = 8'b1111_0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) begin valid_a = 1'b0; din_a = 4'b1010; end
            $display("single cyc=%0d x=%0b done=%0b busy=%0b", i, x_a, done_a, busy_a);
            chk("single_x", x_a, ex_x[7-i]);
            chk("single_done", done_a, ex_d[7-i]);
            chk("single_busy", busy_a, ex_b[7-i]);
        end
        chk("single_ready_end", ready_a, 1);

        // Back-to-back 1100 then 0011 with valid held
        din_a = 4'b1100; valid_a = 1'b1;
        ex_x = 8'b1100_0011; ex_d = 8'b0001_0001; ex_r = 8'b0001_0001;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) din_a = 4'b0011;
            if (i == 4) valid_a = 1'b0;
            $display("b2b cyc=%0d x=%0b done=%0b ready=%0b", i, x_a, done_a, ready_a);
            chk("b2b_x", x_a, ex_x[7-i]);
            chk("b2b_done", done_a, ex_d[7-i]);
            chk("b2b_ready", ready_a, ex_r[7-i]);
            chk("b2b_busy", busy_a, 1);
        end
        tick();
        chk("b2b_end_x", x_a, 0);
        chk("b2b_end_busy", busy_a, 0);

        // Gap of 2, LSB first, word 0001
        din_b = 4'b0001; valid_b = 1'b1;
        ex_x = 8'b1000_0000; ex_d = 8'b0001_0000;
        ex_r = 8'b0000_0010; ex_b = 8'b1111_1100;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0) valid_b = 1'b0;
            $display("gap cyc=%0d x=%0b done=%0b ready=%0b busy=%0b", i, x_b, done_b, ready_b, busy_b);
            chk("gap_x", x_b, ex_x[7-i]);
            chk("gap_done", done_b, ex_d[7-i]);
            chk("gap_ready", ready_b, ex_r[7-i]);
            chk("gap_busy", busy_b, ex_b[7-i]);
        end

        // Reset mid-word on the 8-bit instance
        din_c = 8'hFF; valid_c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) valid_c = 1'b0;
            $display("midrst cyc=%0d x=%0b done=%0b", i, x_c, done_c);
            chk("midrst_x", x_c, 1);
            chk("midrst_done", done_c, 0);
        end
        rst_c = 1'b1; valid_c = 1'b1; din_c = 8'h5A;
        tick();
        rst_c = 1'b0; valid_c = 1'b0;
        chk("midrst_after_x", x_c, 0);
        chk("midrst_after_busy", busy_c, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("midrst_quiet_x", x_c, 0);
            chk("midrst_quiet_done", done_c, 0);
        end
        din_c = 8'hA5; valid_c = 1'b1;
        exc = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) valid_c = 1'b0;
            $display("newword cyc=%0d x=%0b done=%0b", i, x_c, done_c);
            chk("newword_x", x_c, exc[7-i]);
            chk("newword_done", done_c, (i == 7) ? 1 : 0);
        end
        tick();
        chk("newword_end_busy", busy_c, 0);

        // Stall: din toggles while idle without valid
        valid_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din_a = (i % 2 == 0) ? 4'b1111 : 4'b0000;
            tick();
            $display("stall cyc=%0d x=%0b busy=%0b", i, x_a, busy_a);
            chk("stall_x", x_a, 0);
            chk("stall_busy", busy_a, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
